io_hex_display_port: RTL and testbench

//  Memory-mapped I/O port between the single-cycle CPU data bus and the board I/O.
//  CPU stores a binary value; a serial double-dabble FSM converts it to 6 BCD digits
//  and drives six active-low seven-segment displays (hex0..hex5).
//  CPU loads read the synchronised 4-bit switch groups and a busy flag.

---
 rtl/io_hex_display_port.sv | 185 ++++++++++++++++++
 tb/tb_io_hex_display_port.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_hex_display_port.sv
// io_hex_display_port: memory-mapped display/switch port for the CPU data bus.
// A store to BASE_ADDR latches a (saturated) binary value; a serial double-dabble
// converter turns it into six BCD digits shown on active-low seven-segment outputs.
// Loads return the synchronised switch groups and a {pending, busy} status word.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the leading nonzero one.
module io_hex_display_port #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0080,
    parameter logic [31:0] MAX_VALUE = 32'd999999
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        wmem,
    output logic [31:0] ioread_data,
    input  logic [3:0]  sw_a,
    input  logic [3:0]  sw_b,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam logic [29:0] W_VAL  = BASE_ADDR[31:2];
    localparam logic [29:0] W_SWA  = W_VAL + 30'd1;
    localparam logic [29:0] W_SWB  = W_VAL + 30'd2;
    localparam logic [29:0] W_STAT = W_VAL + 30'd3;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] HEX_RST_HI = 7'h7F;
`else
    localparam logic [6:0] HEX_RST_HI = 7'h40;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t      state;
    logic        busy;
    logic        pending;
    logic [31:0] value_q;
    logic [19:0] src;
    logic [19:0] shift_r;
    logic [23:0] bcd;
    logic [23:0] bcd_adj;
    logic [4:0]  cnt;
    logic [3:0]  sw_a_s1, sw_a_s2, sw_b_s1, sw_b_s2;
    logic        store_hit;
    logic [31:0] store_val;
    logic [6:0]  seg_next [6];
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];
    assign store_hit = wmem && (addr[31:2] == W_VAL);
    assign store_val = (datain > MAX_VALUE) ? MAX_VALUE : datain;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Two-flop synchronisers for the asynchronous switch inputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_a_s1 <= '0;
            sw_a_s2 <= '0;
            sw_b_s1 <= '0;
            sw_b_s2 <= '0;
        end else begin
            sw_a_s1 <= sw_a;
            sw_a_s2 <= sw_a_s1;
            sw_b_s1 <= sw_b;
            sw_b_s2 <= sw_b_s1;
        end
    end

    // CPU load data, decoded combinationally from the word address
    always_comb begin
        ioread_data = '0;
        if (addr[31:2] == W_VAL)       ioread_data = value_q;
        else if (addr[31:2] == W_SWA)  ioread_data = {28'b0, sw_a_s2};
        else if (addr[31:2] == W_SWB)  ioread_data = {28'b0, sw_b_s2};
        else if (addr[31:2] == W_STAT) ioread_data = {30'b0, pending, busy};
    end

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 6; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Segment patterns for the finished BCD result, with optional leading-zero blanking
    always_comb begin
        for (int unsigned i = 0; i < 6; i++) seg_next[i] = seg7(bcd[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic higher_nz;
            higher_nz = 1'b0;
            // walk from the top digit down; hex0 is never blanked
            for (int unsigned k = 0; k < 5; k++) begin
                higher_nz = higher_nz | (bcd[4*(5-k) +: 4] != 4'd0);
                if (!higher_nz) seg_next[5-k] = 7'h7F;
            end
        end
`endif
    end

    // Store acceptance, conversion FSM and registered display outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pending <= 1'b0;
            value_q <= '0;
            src     <= '0;
            shift_r <= '0;
            bcd     <= '0;
            cnt     <= '0;
            hex0    <= 7'h40;
            hex1    <= HEX_RST_HI;
            hex2    <= HEX_RST_HI;
            hex3    <= HEX_RST_HI;
            hex4    <= HEX_RST_HI;
            hex5    <= HEX_RST_HI;
        end else begin
            // src doubles as the pending slot: LOAD always converts the latest store
            if (store_hit) begin
                value_q <= store_val;
                src     <= store_val[19:0];
            end
            case (state)
                IDLE: begin
                    if (store_hit) state <= LOAD;
                end
                LOAD: begin
                    shift_r <= src;
                    bcd     <= '0;
                    cnt     <= '0;
                    busy    <= 1'b1;
                    state   <= SHIFT;
                    if (store_hit) pending <= 1'b1;
                end
                SHIFT: begin
                    bcd     <= {bcd_adj[22:0], shift_r[19]};
                    shift_r <= {shift_r[18:0], 1'b0};
                    cnt     <= cnt + 5'd1;
                    if (cnt == 5'd19) state <= DONE;
                    if (store_hit) pending <= 1'b1;
                end
                DONE: begin
                    hex0    <= seg_next[0];
                    hex1    <= seg_next[1];
                    hex2    <= seg_next[2];
                    hex3    <= seg_next[3];
                    hex4    <= seg_next[4];
                    hex5    <= seg_next[5];
                    pending <= 1'b0;
                    if (pending || store_hit) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_hex_display_port.sv
// Testbench for io_hex_display_port: scoreboard of expected display updates
// produced by a decimal-arithmetic model of store timing, plus register reads.
module tb_io_hex_display_port;

    localparam logic [31:0] BASE = 32'h0000_0080;
    localparam int unsigned MAXV = 999999;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] datain = '0;
    logic        wmem = 1'b0;
    logic [31:0] ioread_data;
    logic [3:0]  sw_a = '0;
    logic [3:0]  sw_b = '0;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [41:0] hex_bus;

    io_hex_display_port #(.BASE_ADDR(BASE), .MAX_VALUE(32'd999999)) dut (
        .clock(clock), .resetn(resetn), .addr(addr), .datain(datain), .wmem(wmem),
        .ioread_data(ioread_data), .sw_a(sw_a), .sw_b(sw_b),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    assign hex_bus = {hex5, hex4, hex3, hex2, hex1, hex0};

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int unsigned at;
        logic [41:0] hex;
        int unsigned val;
    } exp_t;
    exp_t sbq[$];

    // Model state: edge at which the current conversion is displayed, pending slot
    int unsigned disp_edge = 0;
    bit          pend_v = 1'b0;
    int unsigned pend_val = 0;
    int unsigned last_val = 0;
    logic [41:0] shown;

    function automatic logic [41:0] ref_hex(input int unsigned v);
        logic [6:0] tbl [10];
        logic [41:0] r;
        logic [6:0] s;
        int unsigned p;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        r = '0;
        p = 1;
        for (int i = 0; i < 6; i++) begin
            s = tbl[(v / p) % 10];
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && v < p) s = 7'h7F;
`endif
            r[7*i +: 7] = s;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int unsigned sat(input logic [31:0] d);
        return (d > MAXV) ? MAXV : int'(d);
    endfunction

    task automatic push_conv(input int unsigned at, input int unsigned v);
        exp_t e;
        e.at = at;
        e.hex = ref_hex(v);
        e.val = v;
        sbq.push_back(e);
    endtask

    // A pending value starts converting at the display edge of the one before it
    task automatic resolve(input int unsigned t);
        if (pend_v && t > disp_edge) begin
            disp_edge = disp_edge + 22;
            push_conv(disp_edge, pend_val);
            pend_v = 1'b0;
        end
    endtask

    task automatic model_store(input int unsigned t, input int unsigned v);
        resolve(t);
        last_val = v;
        if (t >= disp_edge) begin
            disp_edge = t + 22;
            pend_v = 1'b0;
            push_conv(disp_edge, v);
        end else begin
            pend_v = 1'b1;
            pend_val = v;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clock);
        wmem = 1'b0;
        resolve(cyc + 1);
    endtask

    task automatic store(input logic [31:0] d);
        step();
        addr = BASE;
        datain = d;
        wmem = 1'b1;
        model_store(cyc + 1, sat(d));
    endtask

    task automatic bad_store(input logic [31:0] d);
        step();
        addr = BASE + 32'h4;
        datain = d;
        wmem = 1'b1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        check(name, ioread_data, exp);
    endtask

    task automatic reset_dut();
        @(negedge clock);
        wmem = 1'b0;
        resetn = 1'b0;
        sbq.delete();
        pend_v = 1'b0;
        disp_edge = 0;
        last_val = 0;
        shown = ref_hex(0);
        #1;
        check("reset_hex_lo", hex_bus[31:0], shown[31:0]);
        check("reset_hex_hi", {22'b0, hex_bus[41:32]}, {22'b0, shown[41:32]});
        rd(BASE + 32'hC, 32'h0, "reset_status");
        rd(BASE, 32'h0, "reset_value");
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // Monitor: pops an expectation on its display edge, flags any other change
    initial begin
        exp_t e;
        shown = ref_hex(0);
        forever begin
            @(posedge clock);
            #1;
            if (sbq.size() > 0 && sbq[0].at == cyc) begin
                e = sbq.pop_front();
                shown = e.hex;
                vectors++;
                if (hex_bus !== e.hex) begin
                    miscompares++;
                    $display("FAIL display(%0d): got %h expected %h (cycle %0d)", e.val, hex_bus, e.hex, cyc);
                end
            end else if (hex_bus !== shown) begin
                miscompares++;
                $display("FAIL hex_unexpected: got %h expected %h (cycle %0d)", hex_bus, shown, cyc);
                shown = hex_bus;
            end
            if (sbq.size() > 0 && sbq[0].at < cyc) begin
                e = sbq.pop_front();
                miscompares++;
                $display("FAIL display_missed(%0d): got none expected %h at %0d", e.val, e.hex, e.at);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        logic [3:0] a, b, old_a;
        logic [31:0] d;
        int unsigned budget;

        repeat (3) @(negedge clock);
        reset_dut();

        // Single conversion with busy window
        store(32'd123456);
        n = cyc + 1;
        for (int k = 0; k < 23; k++) begin
            step();
            rd(BASE + 32'hC, {30'b0, 1'b0, (cyc >= n + 1 && cyc <= n + 21)}, "busy_window");
        end
        rd(BASE, 32'd123456, "value_123456");

        // Saturation
        store(32'h00FF_FFFF);
        step();
        rd(BASE, 32'd999999, "value_saturated");
        repeat (24) step();

        // Stores while busy: last one wins, the middle one is never shown
        store(32'd42);
        n = cyc + 1;
        repeat (4) step();
        store(32'd7);
        repeat (2) step();
        store(32'd9);
        step();
        rd(BASE + 32'hC, 32'h3, "pending_set");
        while (cyc < n + 22) step();
        rd(BASE + 32'hC, 32'h1, "pending_cleared");
        rd(BASE, 32'd9, "value_last_store");
        repeat (24) step();

        // Switch synchronisers and unmapped addresses
        for (int k = 0; k < 4; k++) begin
            old_a = sw_a;
            a = (k == 0) ? 4'hA : 4'($urandom);
            b = (k == 0) ? 4'h5 : 4'($urandom);
            step();
            sw_a = a;
            sw_b = b;
            step();
            rd(BASE + 32'h4, {28'b0, old_a}, "sw_a_one_edge");
            step();
            rd(BASE + 32'h4, {28'b0, a}, "sw_a_sync");
            rd(BASE + 32'h8, {28'b0, b}, "sw_b_sync");
        end
        rd(BASE + 32'h10, 32'h0, "unmapped_0x10");
        rd(BASE - 32'h4, 32'h0, "unmapped_below");
        rd(BASE + 32'h3, {12'b0, 20'(last_val)}, "value_byte_offset");

        // Reset mid-conversion, then a small value
        store(32'd123456);
        repeat (10) step();
        reset_dut();
        store(32'd42);
        repeat (24) step();

        // Randomised stores with random spacing
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: d = $urandom_range(0, 99);
                1: d = $urandom;
                2: d = (k % 2 == 0) ? 32'd999999 : 32'd1000000;
                default: d = $urandom_range(0, 999999);
            endcase
            if ($urandom_range(0, 7) == 0) begin
                bad_store($urandom);
                step();
                rd(BASE, last_val, "ignored_store");
            end else begin
                store(d);
                step();
                rd(BASE, last_val, "value_random");
            end
            repeat ($urandom_range(0, 30)) step();
        end

        budget = 0;
        while ((sbq.size() > 0 || pend_v) && budget < 200) begin
            step();
            budget++;
        end
        vectors++;
        if (sbq.size() > 0 || pend_v) begin
            miscompares++;
            $display("FAIL drain: got %0d outstanding expected 0", sbq.size());
        end
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
